run_decoder: RTL

//  Inverse of run_encoder on the JPEG decode path. Takes one block's

---
 rtl/run_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/run_decoder.sv
// run_decoder: rebuilds one block of 64 zigzag-ordered quantized coefficients
// from a DC difference followed by AC (run, size, value) / ZRL / EOB symbols.
// One coefficient leaves per output handshake through a single output register.
module run_decoder #(
   parameter int W_AC   = 10,
   parameter int W_COEF = 11,
   parameter int NCOEF  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_AC-1:0]   in,
   input  logic [W_COEF-1:0] in_dc,
   input  logic [3:0]        run,
   input  logic [3:0]        size,
   input  logic              dc,
   input  logic              ena_in,
   output logic              rdy_out,
   output logic [W_COEF-1:0] out,
   output logic              ena_out,
   input  logic              rdy_in,
   output logic              done,
   output logic              err
);

   localparam int W_IDX = $clog2(NCOEF);
   localparam int W_Z   = W_IDX + 1;   // zero counter must hold NCOEF itself

   typedef enum logic [1:0] {S_DC, S_AC, S_EMIT} state_t;

   state_t              r_state, w_state_nxt;
   logic [W_IDX-1:0]    r_idx;
   logic [W_COEF-1:0]   r_pred, r_out, r_val;
   logic [W_Z-1:0]      r_zrem;
   logic                r_pend, r_ena_out, r_done, r_err;

   logic                w_slot_free, w_acc, w_emit, w_done, w_err_set, w_pred_upd;
   logic [W_COEF-1:0]   w_coef, w_dc_sum, w_val_src;
   logic [W_Z-1:0]      w_zrem_src, w_zrem_left;
   logic                w_pend_src, w_pend_left, w_ac_emit;

   assign w_slot_free = !r_ena_out || rdy_in;
   // rdy_out is forced low while reset is held so nothing is taken mid-reset
   assign rdy_out     = rst && w_slot_free && (r_state != S_EMIT);
   assign w_acc       = ena_in && rdy_out;
   assign w_dc_sum    = r_pred + in_dc;

   assign out     = r_out;
   assign ena_out = r_ena_out;
   assign done    = r_done;
   assign err     = r_err;

   // Next state plus the coefficient produced this cycle, if any
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_ac_emit   = 1'b0;
      w_done      = 1'b0;
      w_err_set   = 1'b0;
      w_pred_upd  = 1'b0;
      w_coef      = '0;
      w_zrem_src  = r_zrem;
      w_pend_src  = r_pend;
      w_val_src   = r_val;
      w_zrem_left = r_zrem;
      w_pend_left = r_pend;
      case (r_state)
         S_DC: begin
            if (w_acc) begin
               if (dc) begin
                  w_emit      = 1'b1;
                  w_coef      = w_dc_sum;
                  w_pred_upd  = 1'b1;
                  w_zrem_left = '0;
                  w_pend_left = 1'b0;
                  w_state_nxt = S_AC;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         S_AC: begin
            if (w_acc) begin
               if (dc) begin
                  w_err_set = 1'b1;
               end else begin
                  w_ac_emit = 1'b1;
                  if (size == 4'd0) begin
                     w_pend_src = 1'b0;
                     if (run == 4'd0) begin
                        // EOB: zero-fill to the end of the block
                        w_zrem_src = W_Z'(NCOEF) - {1'b0, r_idx};
                     end else begin
                        // ZRL; any other run with size 0 is malformed but still skips 16
                        w_zrem_src = W_Z'(16);
                        if (run != 4'd15) w_err_set = 1'b1;
                     end
                  end else begin
                     w_zrem_src = W_Z'(run);
                     w_pend_src = 1'b1;
                     w_val_src  = {{(W_COEF-W_AC){in[W_AC-1]}}, in};
                  end
               end
            end
         end
         S_EMIT: begin
            if (w_slot_free) w_ac_emit = 1'b1;
         end
         default: w_state_nxt = S_DC;
      endcase

      if (w_ac_emit) begin
         w_emit = 1'b1;
         if (w_zrem_src != '0) begin
            w_coef      = '0;
            w_zrem_left = w_zrem_src - W_Z'(1);
            w_pend_left = w_pend_src;
         end else begin
            w_coef      = w_val_src;
            w_zrem_left = '0;
            w_pend_left = 1'b0;
         end
         if (r_idx == W_IDX'(NCOEF-1)) begin
            // last slot closes the block; anything still owed is lost
            w_done      = 1'b1;
            w_state_nxt = S_DC;
            if ((w_zrem_left != '0) || w_pend_left) w_err_set = 1'b1;
            w_zrem_left = '0;
            w_pend_left = 1'b0;
         end else if ((w_zrem_left == '0) && !w_pend_left) begin
            w_state_nxt = S_AC;
         end else begin
            w_state_nxt = S_EMIT;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_DC;
      else      r_state <= w_state_nxt;
   end

   // Datapath: predictor, index, pending work and the output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx     <= '0;
         r_pred    <= '0;
         r_zrem    <= '0;
         r_pend    <= 1'b0;
         r_val     <= '0;
         r_out     <= '0;
         r_ena_out <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_err_set)  r_err  <= 1'b1;
         if (w_pred_upd) r_pred <= w_dc_sum;
         if (w_emit) begin
            r_out     <= w_coef;
            r_ena_out <= 1'b1;
            r_done    <= w_done;
            r_idx     <= w_done ? '0 : r_idx + W_IDX'(1);
            r_zrem    <= w_zrem_left;
            r_pend    <= w_pend_left;
            r_val     <= w_val_src;
         end else if (w_slot_free) begin
            r_ena_out <= 1'b0;
            r_done    <= 1'b0;
         end
      end
   end

endmodule
